// File: rtl/wb_arbiter2_if.sv
// Wishbone B4 pipelined link types and bundle shared by both masters and the slave side.
// Latency: none, pure wiring; the arbiter decides all timing.
// Backpressure: carried by stall (pipelined Wishbone), responses by ack/err.
package wb_pkg;
  typedef logic [31:0] adr_t;
  typedef logic [3:0]  sel_t;
  typedef logic [31:0] dat_t;
endpackage

interface wb_arbiter2_if;
  import wb_pkg::*;

  logic cyc;
  logic stb;
  logic we;
  adr_t adr;
  sel_t sel;
  dat_t dat_m;
  dat_t dat_s;
  logic ack;
  logic err;
  logic stall;

  // Initiator view: drives the request, receives responses.
  modport master (
    output cyc, stb, we, adr, sel, dat_m,
    input  dat_s, ack, err, stall
  );

  // Target view: receives the request, drives responses.
  modport slave (
    input  cyc, stb, we, adr, sel, dat_m,
    output dat_s, ack, err, stall
  );
endinterface

// File: rtl/wb_arbiter2.sv
// Round-robin two-master to one-slave Wishbone B4 pipelined arbiter; ownership held for a whole CYC.
// Latency: one cycle to grant, then requests/responses pass combinationally; one IDLE bubble between owners.
// Backpressure: owner stalls on s_stall or when MAX_OUTSTANDING strobes are unanswered; WB_ARB_TIMEOUT_EN adds a slave-timeout abort.
module wb_arbiter2 #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT         = 16
) (
  input  logic          clk,
  input  logic          rst,
  wb_arbiter2_if.slave  m0,
  wb_arbiter2_if.slave  m1,
  wb_arbiter2_if.master s
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, FLUSH} state_t;
`else
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
`endif

  state_t        state_q, state_d;
  logic          last_q, last_d;      // previous / current owner: 0 = m0, 1 = m1
  logic [CW-1:0] out_q, out_d;        // accepted but unanswered strobes
`ifdef WB_ARB_TIMEOUT_EN
  logic [TW-1:0] timer_q, timer_d;
`endif

  logic own_cyc, own_stb;
  logic own_ack, own_err, own_stall;
  logic rsp, room, acc;

  // While granted, last_q is the owner, so it also steers the data path.
  assign own_cyc = last_q ? m1.cyc : m0.cyc;
  assign own_stb = last_q ? m1.stb : m0.stb;
  assign rsp     = s.ack | s.err;
  // A response in the same cycle frees a slot, so a full pipeline still accepts one strobe then.
  assign room    = (out_q != MAX_CNT) | rsp;

  // State, owner and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      out_q   <= '0;
`ifdef WB_ARB_TIMEOUT_EN
      timer_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      out_q   <= out_d;
`ifdef WB_ARB_TIMEOUT_EN
      timer_q <= timer_d;
`endif
    end
  end

  // Next-state logic plus bus muxing and response routing.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    out_d   = out_q;
`ifdef WB_ARB_TIMEOUT_EN
    timer_d = '0;
`endif
    acc       = 1'b0;
    own_ack   = 1'b0;
    own_err   = 1'b0;
    own_stall = 1'b1;

    s.cyc   = 1'b0;
    s.stb   = 1'b0;
    s.we    = m0.we;
    s.adr   = m0.adr;
    s.sel   = m0.sel;
    s.dat_m = m0.dat_m;

    m0.dat_s = s.dat_s;
    m1.dat_s = s.dat_s;
    m0.ack   = 1'b0;
    m0.err   = 1'b0;
    m0.stall = 1'b1;
    m1.ack   = 1'b0;
    m1.err   = 1'b0;
    m1.stall = 1'b1;

    unique case (state_q)
      IDLE: begin
        out_d = '0;
        if (m0.cyc && m1.cyc) begin
          // Contention: the master that did not own last time wins.
          state_d = last_q ? GNT0 : GNT1;
          last_d  = ~last_q;
        end else if (m0.cyc) begin
          state_d = GNT0;
          last_d  = 1'b0;
        end else if (m1.cyc) begin
          state_d = GNT1;
          last_d  = 1'b1;
        end
      end

      GNT0, GNT1: begin
        if (last_q) begin
          s.we    = m1.we;
          s.adr   = m1.adr;
          s.sel   = m1.sel;
          s.dat_m = m1.dat_m;
        end
        s.cyc     = own_cyc;
        s.stb     = own_stb & room;
        own_ack   = s.ack;
        own_err   = s.err;
        own_stall = s.stall | ~room;
        acc       = own_cyc & own_stb & room & ~s.stall;

        unique case ({acc, rsp})
          2'b10:   out_d = out_q + CW'(1);
          2'b01:   out_d = out_q - CW'(1);
          default: out_d = out_q;
        endcase

`ifdef WB_ARB_TIMEOUT_EN
        if (out_q == '0 || rsp) begin
          timer_d = '0;
        end else if (timer_q == TMAX) begin
          timer_d = '0;
          state_d = FLUSH;
        end else begin
          timer_d = timer_q + TW'(1);
        end
`endif

        // Owner released the bus: any late slave response is dropped.
        if (!own_cyc) begin
          state_d = IDLE;
          out_d   = '0;
        end
      end

`ifdef WB_ARB_TIMEOUT_EN
      FLUSH: begin
        // Slave is cut off; one ERR per abandoned strobe goes back to the owner.
        if (out_q != '0) begin
          own_err = 1'b1;
          out_d   = out_q - CW'(1);
        end else if (own_cyc) begin
          state_d = last_q ? GNT1 : GNT0;
        end else begin
          state_d = IDLE;
        end
      end
`endif

      default: begin
        state_d = IDLE;
        out_d   = '0;
      end
    endcase

    if (last_q) begin
      m1.ack   = own_ack;
      m1.err   = own_err;
      m1.stall = own_stall;
    end else begin
      m0.ack   = own_ack;
      m0.err   = own_err;
      m0.stall = own_stall;
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: a table of per-cycle vectors plus sequences for addressing, reset and timeout.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Slave responses are scripted per cycle, so stall/ack timing is fully controlled.
module tb_wb_arbiter2;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_arbiter2_if m0_bus();
  wb_arbiter2_if m1_bus();
  wb_arbiter2_if s_bus();

  wb_arbiter2 dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_bus),
    .m1  (m1_bus),
    .s   (s_bus)
  );

  localparam adr_t M0_ADR = 32'h0000_1000;
  localparam adr_t M1_ADR = 32'h0000_2000;
  localparam logic [8:0] IDLE_OUT = 9'b00_001_001_0;

  int n_chk  = 0;
  int n_fail = 0;

  // in : {rst | m0 cyc stb | m1 cyc stb | s ack err stall}
  // exp: {s_cyc s_stb | m0 ack err stall | m1 ack err stall | s_adr is m1's}
  typedef struct packed {
    logic [7:0] in;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [7:0] v);
    rst          = v[7];
    m0_bus.cyc   = v[6];
    m0_bus.stb   = v[5];
    m1_bus.cyc   = v[4];
    m1_bus.stb   = v[3];
    s_bus.ack    = v[2];
    s_bus.err    = v[1];
    s_bus.stall  = v[0];
  endtask

  task automatic drive(input logic [7:0] v);
    @(posedge clk);
    #1;
    set_in(v);
    @(negedge clk);
  endtask

  function automatic logic [8:0] observe();
    return {s_bus.cyc, s_bus.stb, m0_bus.ack, m0_bus.err, m0_bus.stall,
            m1_bus.ack, m1_bus.err, m1_bus.stall, (s_bus.adr == M1_ADR)};
  endfunction

  task automatic add(input logic [7:0] in, input logic [8:0] exp);
    vec_t v;
    v.in  = in;
    v.exp = exp;
    tbl.push_back(v);
  endtask

  initial begin
    int errs;
    bit back;
    bit flush_ok;

    set_in(8'b1_00_00_000);
    m0_bus.we = 1'b0;  m0_bus.adr = M0_ADR; m0_bus.sel = 4'hF; m0_bus.dat_m = 32'hAAAA_0000;
    m1_bus.we = 1'b1;  m1_bus.adr = M1_ADR; m1_bus.sel = 4'h3; m1_bus.dat_m = 32'hBBBB_0000;
    s_bus.dat_s = 32'h1234_5678;
    drive(8'b1_00_00_000);
    drive(8'b1_00_00_000);

    // Reset state, then single master m0 with a zero-wait slave.
    add(8'b0_00_00_000, IDLE_OUT);
    add(8'b0_11_00_000, IDLE_OUT);          // grant takes one cycle
    add(8'b0_11_00_000, 9'b11_000_001_0);
    add(8'b0_11_00_100, 9'b11_100_001_0);
    add(8'b0_11_00_100, 9'b11_100_001_0);
    add(8'b0_11_00_100, 9'b11_100_001_0);
    add(8'b0_10_00_100, 9'b10_100_001_0);   // 4th ack
    add(8'b0_00_00_000, 9'b00_000_001_0);   // m0 drops cyc
    // Contention after reset: m0 first, one bubble, then m1, then m0 again.
    add(8'b1_00_00_000, IDLE_OUT);
    add(8'b0_10_10_000, IDLE_OUT);
    add(8'b0_11_11_000, 9'b11_000_001_0);
    add(8'b0_10_11_100, 9'b10_100_001_0);
    add(8'b0_00_11_000, 9'b00_000_001_0);
    add(8'b0_00_11_000, IDLE_OUT);          // bubble between owners
    add(8'b0_00_11_000, 9'b11_001_000_1);
    add(8'b0_00_10_100, 9'b10_001_100_1);
    add(8'b0_11_00_000, 9'b00_001_000_1);
    add(8'b0_10_10_000, IDLE_OUT);
    add(8'b0_10_10_000, 9'b10_000_001_0);   // m0 wins the repeat contention
    add(8'b0_00_00_000, 9'b00_000_001_0);
    // m1 three writes, error on the second.
    add(8'b0_00_11_000, IDLE_OUT);
    add(8'b0_00_11_000, 9'b11_001_000_1);
    add(8'b0_00_11_100, 9'b11_001_100_1);
    add(8'b0_00_11_010, 9'b11_001_010_1);
    add(8'b0_00_10_100, 9'b10_001_100_1);
    add(8'b0_00_00_000, 9'b00_001_000_1);
    // Throttle at 4 outstanding; release in the ack cycle.
    add(8'b0_11_00_000, IDLE_OUT);
    add(8'b0_11_00_000, 9'b11_000_001_0);
    add(8'b0_11_00_000, 9'b11_000_001_0);
    add(8'b0_11_00_000, 9'b11_000_001_0);
    add(8'b0_11_00_000, 9'b11_000_001_0);   // 4th accepted
    add(8'b0_11_00_000, 9'b10_001_001_0);
    add(8'b0_11_00_000, 9'b10_001_001_0);
    add(8'b0_11_00_100, 9'b11_100_001_0);   // 5th accepted with first ack
    add(8'b0_11_00_000, 9'b10_001_001_0);
    add(8'b0_10_00_100, 9'b10_100_001_0);
    add(8'b0_11_00_001, 9'b11_001_001_0);   // slave stall
    add(8'b0_00_00_000, 9'b00_000_001_0);   // drop with 3 outstanding
    add(8'b0_00_00_100, IDLE_OUT);          // late ack dropped

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].in);
      check($sformatf("vec%0d", i), 32'(observe()), 32'(tbl[i].exp));
    end

    // Four pipelined reads at 0x0..0xC with read data routed to m0.
    drive(8'b0_11_00_000);
    check("a_grant_latency", 32'(s_bus.cyc), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      m0_bus.adr  = adr_t'(i * 4);
      s_bus.ack   = (i > 0);
      s_bus.dat_s = 32'hD000_0000 + 32'(i);
      @(negedge clk);
      check($sformatf("a_adr%0d", i), s_bus.adr, 32'(i * 4));
      check($sformatf("a_ack%0d", i), 32'(m0_bus.ack), 32'(i > 0));
      check($sformatf("a_dat%0d", i), m0_bus.dat_s, 32'hD000_0000 + 32'(i));
      check($sformatf("a_m1stall%0d", i), 32'(m1_bus.stall), 32'd1);
    end
    drive(8'b0_10_00_100);
    check("a_last_ack", 32'(m0_bus.ack), 32'd1);
    drive(8'b0_00_00_000);
    m0_bus.adr = M0_ADR;

    // Reset with 3 outstanding; stray acks afterwards must go nowhere.
    drive(8'b0_11_00_000);
    drive(8'b0_11_00_000);
    drive(8'b0_11_00_000);
    drive(8'b0_11_00_000);
    check("b_pre_rst_scyc", 32'(s_bus.cyc), 32'd1);
    drive(8'b1_11_00_000);
    drive(8'b0_00_00_100);
    check("b_after_rst", 32'(observe()), 32'(IDLE_OUT));
    drive(8'b0_00_00_100);
    check("b_stray_ack", 32'(observe()), 32'(IDLE_OUT));

`ifdef WB_ARB_TIMEOUT_EN
    // Slave never answers two strobes: expect two ERR pulses then regrant.
    drive(8'b0_11_00_000);
    drive(8'b0_11_00_000);
    drive(8'b0_11_00_000);
    errs     = 0;
    back     = 1'b0;
    flush_ok = 1'b1;
    for (int i = 0; i < 60 && !back; i++) begin
      drive(8'b0_10_00_000);
      if (m0_bus.err === 1'b1) begin
        errs++;
        if (s_bus.cyc !== 1'b0) flush_ok = 1'b0;
      end else if (errs > 0 && s_bus.cyc === 1'b1) begin
        back = 1'b1;
      end
    end
    check("c_flush_errs", 32'(errs), 32'd2);
    check("c_flush_scyc", 32'(flush_ok), 32'd1);
    check("c_regrant", 32'(back), 32'd1);
    drive(8'b0_00_00_000);
`else
    errs     = 0;
    back     = 1'b0;
    flush_ok = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
